mips_instr_encoder: RTL

Boot-time instruction loader and encoder for the single-cycle MIPS core. It performs the inverse of the control/ALU decode path: it takes field-level instruction commands (mnemonic class plus register, immediate and target fields) over a valid/ready handshake and packs each one into a 32-bit MIPS word. Encoded words are written at consecutive instruction-memory addresses. The CPU is held off until loading completes.

---
 rtl/mips_enc_pkg.sv | 76 +++++++
 rtl/mips_enc_if.sv | 30 +++
 rtl/mips_field_packer.sv | 33 +++
 rtl/mips_instr_encoder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mips_enc_pkg.sv
// Shared types and constants for the MIPS instruction encoder/loader.
// Optional build macro used by the encoder: ENC_CHECKSUM_EN.
package mips_enc_pkg;

    // Field-level mnemonic classes accepted on the command bus
    typedef enum logic [3:0] {
        CMD_ADD  = 4'd0,
        CMD_SUB  = 4'd1,
        CMD_AND  = 4'd2,
        CMD_OR   = 4'd3,
        CMD_SLT  = 4'd4,
        CMD_JR   = 4'd5,
        CMD_LW   = 4'd6,
        CMD_SW   = 4'd7,
        CMD_BEQ  = 4'd8,
        CMD_ADDI = 4'd9,
        CMD_J    = 4'd10
    } cmd_op_e;

    // Loader session states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_e;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned OPC_W    = 6;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned IMM_W    = 16;
    localparam int unsigned TARGET_W = 26;

    // Primary opcodes
    localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OP_J     = 6'h02;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [OPC_W-1:0] FN_JR  = 6'h08;
    localparam logic [OPC_W-1:0] FN_ADD = 6'h20;
    localparam logic [OPC_W-1:0] FN_SUB = 6'h22;
    localparam logic [OPC_W-1:0] FN_AND = 6'h24;
    localparam logic [OPC_W-1:0] FN_OR  = 6'h25;
    localparam logic [OPC_W-1:0] FN_SLT = 6'h2A;

    // Command payload handed to the field packer
    typedef struct packed {
        cmd_op_e               op;
        logic [REG_W-1:0]      rs;
        logic [REG_W-1:0]      rt;
        logic [REG_W-1:0]      rd;
        logic [IMM_W-1:0]      imm;
        logic [TARGET_W-1:0]   target;
    } enc_cmd_t;

    // R-type layout: op | rs | rt | rd | shamt(0) | funct
    function automatic logic [WORD_W-1:0] r_word(input logic [REG_W-1:0] rs,
                                                 input logic [REG_W-1:0] rt,
                                                 input logic [REG_W-1:0] rd,
                                                 input logic [OPC_W-1:0] fn);
        return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    // I-type layout: op | rs | rt | imm
    function automatic logic [WORD_W-1:0] i_word(input logic [OPC_W-1:0] op,
                                                 input logic [REG_W-1:0] rs,
                                                 input logic [REG_W-1:0] rt,
                                                 input logic [IMM_W-1:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/mips_enc_if.sv
// Command handshake and instruction-memory write bus of the encoder.
interface mips_enc_if #(
    parameter int unsigned ADDR_W = 6
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_op;
    logic [4:0]    cmd_rs;
    logic [4:0]    cmd_rt;
    logic [4:0]    cmd_rd;
    logic [15:0]   cmd_imm;
    logic [25:0]   cmd_target;
    logic          cmd_last;

    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;

    // Command source side; observes the memory writes
    modport master (
        output cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_imm, cmd_target, cmd_last,
        input  cmd_ready, im_we, im_addr, im_wdata
    );

    // Encoder side
    modport slave (
        input  cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_imm, cmd_target, cmd_last,
        output cmd_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/mips_field_packer.sv
// Combinational packer: command fields in, 32-bit MIPS word plus illegal flag out.
module mips_field_packer
    import mips_enc_pkg::*;
(
    input  enc_cmd_t            cmd,
    output logic [WORD_W-1:0]   word_c,
    output logic                illegal_c
);

    // Select the layout by mnemonic; unknown mnemonics become a NOP
    always_comb begin
        word_c    = '0;
        illegal_c = 1'b0;
        case (cmd.op)
            CMD_ADD:  word_c = r_word(cmd.rs, cmd.rt, cmd.rd, FN_ADD);
            CMD_SUB:  word_c = r_word(cmd.rs, cmd.rt, cmd.rd, FN_SUB);
            CMD_AND:  word_c = r_word(cmd.rs, cmd.rt, cmd.rd, FN_AND);
            CMD_OR:   word_c = r_word(cmd.rs, cmd.rt, cmd.rd, FN_OR);
            CMD_SLT:  word_c = r_word(cmd.rs, cmd.rt, cmd.rd, FN_SLT);
            CMD_JR:   word_c = r_word(cmd.rs, 5'd0, 5'd0, FN_JR);
            CMD_LW:   word_c = i_word(OP_LW,   cmd.rs, cmd.rt, cmd.imm);
            CMD_SW:   word_c = i_word(OP_SW,   cmd.rs, cmd.rt, cmd.imm);
            CMD_BEQ:  word_c = i_word(OP_BEQ,  cmd.rs, cmd.rt, cmd.imm);
            CMD_ADDI: word_c = i_word(OP_ADDI, cmd.rs, cmd.rt, cmd.imm);
            CMD_J:    word_c = {OP_J, cmd.target};
            default: begin
                word_c    = '0;
                illegal_c = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// Boot-time instruction loader: encodes field-level commands and writes them to
// consecutive instruction-memory words while holding the CPU off.
// Build option: define ENC_CHECKSUM_EN to keep a running XOR of written words.
module mips_instr_encoder
    import mips_enc_pkg::*;
#(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    mips_enc_if.slave           bus,
    output logic                busy,
    output logic                done,
    output logic                cpu_hold,
    output logic                err_illegal,
    output logic                err_full,
    output logic [ADDR_W:0]     word_count,
    output logic [WORD_W-1:0]   checksum
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

    enc_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                im_we_q, im_we_d;
    logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
    logic [WORD_W-1:0]   im_wdata_q, im_wdata_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                err_illegal_q, err_illegal_d;
    logic                err_full_q, err_full_d;
    logic [CNT_W-1:0]    word_count_q, word_count_d;
`ifdef ENC_CHECKSUM_EN
    logic [WORD_W-1:0]   checksum_q, checksum_d;
`endif

    enc_cmd_t            cmd_c;
    logic [WORD_W-1:0]   pack_word_c;
    logic                pack_illegal_c;
    logic                accept_c;

    // Repack the bus fields into the packer payload
    always_comb begin
        cmd_c.op     = cmd_op_e'(bus.cmd_op);
        cmd_c.rs     = bus.cmd_rs;
        cmd_c.rt     = bus.cmd_rt;
        cmd_c.rd     = bus.cmd_rd;
        cmd_c.imm    = bus.cmd_imm;
        cmd_c.target = bus.cmd_target;
    end

    mips_field_packer u_packer (
        .cmd       (cmd_c),
        .word_c    (pack_word_c),
        .illegal_c (pack_illegal_c)
    );

    assign accept_c = (state_q == ST_LOAD) && bus.cmd_valid && cmd_ready_q;

    // Next-state, counter and write-stage logic
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        im_we_d       = 1'b0;
        im_addr_d     = im_addr_q;
        im_wdata_d    = im_wdata_q;
        err_illegal_d = err_illegal_q;
        err_full_d    = err_full_q;
        word_count_d  = word_count_q + CNT_W'(im_we_q);
`ifdef ENC_CHECKSUM_EN
        checksum_d    = im_we_q ? (checksum_q ^ im_wdata_q) : checksum_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d       = ST_LOAD;
                    addr_d        = BASE;
                    word_count_d  = '0;
                    err_illegal_d = 1'b0;
                    err_full_d    = 1'b0;
`ifdef ENC_CHECKSUM_EN
                    checksum_d    = '0;
`endif
                end
            end
            ST_LOAD: begin
                if (accept_c) begin
                    im_we_d    = 1'b1;
                    im_addr_d  = addr_q;
                    im_wdata_d = pack_word_c;
                    if (pack_illegal_c) begin
                        err_illegal_d = 1'b1;
                    end
                    // The top word ends the session; the address does not wrap
                    if (addr_q == LAST_ADDR) begin
                        state_d = ST_FLUSH;
                        if (!bus.cmd_last) begin
                            err_full_d = 1'b1;
                        end
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                        if (bus.cmd_last) begin
                            state_d = ST_FLUSH;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_LOAD) && (word_count_d != FULL_CNT);
        busy_d      = (state_d == ST_LOAD) || (state_d == ST_FLUSH);
        done_d      = (state_d == ST_DONE);
        cpu_hold_d  = (state_d != ST_DONE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= BASE;
            im_we_q       <= 1'b0;
            im_addr_q     <= BASE;
            im_wdata_q    <= '0;
            cmd_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cpu_hold_q    <= 1'b1;
            err_illegal_q <= 1'b0;
            err_full_q    <= 1'b0;
            word_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            im_we_q       <= im_we_d;
            im_addr_q     <= im_addr_d;
            im_wdata_q    <= im_wdata_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cpu_hold_q    <= cpu_hold_d;
            err_illegal_q <= err_illegal_d;
            err_full_q    <= err_full_d;
            word_count_q  <= word_count_d;
        end
    end

`ifdef ENC_CHECKSUM_EN
    // Running XOR of every word written this session
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.im_we     = im_we_q;
    assign bus.im_addr   = im_addr_q;
    assign bus.im_wdata  = im_wdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign cpu_hold      = cpu_hold_q;
    assign err_illegal   = err_illegal_q;
    assign err_full      = err_full_q;
    assign word_count    = word_count_q;

endmodule
